// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared constants and the controller state type for the instruction fetch
// buffer.
//   WORD_BYTES  - bytes per iram word
//   INSTR_BYTES - bytes presented to fetch per window
//   MAX_WORDS   - words held in the buffer
//   state_t     - controller states
// ---------------------------------------------------------------------------
package ifetch_pkg;

    localparam int WORD_BYTES  = 8;
    localparam int INSTR_BYTES = 10;
    localparam int MAX_WORDS   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/ifetch_align.sv
// ---------------------------------------------------------------------------
// ifetch_align
// Combinational window extraction. Errored words are zeroed, then the 24-byte
// concatenation {w2,w1,w0} is shifted down by the byte offset and the low
// 10 bytes are returned.
//   words  in  192  {w2,w1,w0}, byte j of the buffer at bits [8j+7:8j]
//   err    in  3    per-word error flags
//   offset in  3    byte offset of the PC inside word 0
//   window out 80   byte offset+k at bits [8k+7:8k]
// ---------------------------------------------------------------------------
module ifetch_align
    import ifetch_pkg::*;
(
    input  logic [MAX_WORDS*WORD_BYTES*8-1:0] words,
    input  logic [MAX_WORDS-1:0]              err,
    input  logic [2:0]                        offset,
    output logic [INSTR_BYTES*8-1:0]          window
);

    logic [MAX_WORDS*WORD_BYTES*8-1:0] masked;
    logic [MAX_WORDS*WORD_BYTES*8-1:0] shifted;

    always_comb begin
        masked = words;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (err[i]) begin
                masked[i*64 +: 64] = 64'd0;
            end
        end
        // Offset is in bytes; append three zero bits to get a bit shift.
        shifted = masked >> {offset, 3'b000};
        window  = shifted[INSTR_BYTES*8-1:0];
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
// Instruction front end: takes a byte PC, reads the aligned 64-bit words it
// needs from iram (one outstanding read), keeps up to three consecutive words
// for reuse by sequential PCs, and presents the 10-byte window at PC.
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   pc_i/pc_valid_i/pc_ready_o     PC request (accepted only in IDLE)
//   flush_i              abort request, invalidate buffer
//   mem_req_o/mem_addr_o one-cycle read pulse and aligned word address
//   mem_rdata_i/mem_valid_i/mem_error_i  read response
//   instr_o/instr_valid_o/instr_ready_i  window to fetch
//   imem_error_o         window contains an errored word
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised the payload is held stable until that edge.
// ---------------------------------------------------------------------------
module instr_fetch_buffer
    import ifetch_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [63:0]       mem_rdata_i,
    input  logic              mem_valid_i,
    input  logic              mem_error_i,
    output logic [79:0]       instr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic              imem_error_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        off_q;
    logic              need3_q;
    logic [63:0]       word_q [MAX_WORDS];
    logic [2:0]        vld_q;
    logic [2:0]        err_q;
    logic [1:0]        idx_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic [2:0]        need_mask;
    logic [2:0]        missing;
    logic              all_hit;
    logic [1:0]        miss_idx;
    logic              win_err;
    logic [ADDR_W-1:0] new_base;
    logic [ADDR_W-1:0] delta;
    logic [79:0]       window;

    assign need_mask = need3_q ? 3'b111 : 3'b011;
    assign missing   = need_mask & ~vld_q;
    assign all_hit   = (missing == 3'b000);
    assign miss_idx  = missing[0] ? 2'd0 : (missing[1] ? 2'd1 : 2'd2);
    assign win_err   = |(need_mask & err_q);
    assign new_base  = {pc_i[ADDR_W-1:3], 3'b000};
    // Modulo-2^ADDR_W difference, so base+8/base+16 wrap naturally.
    assign delta     = new_base - base_q;

    ifetch_align u_align (
        .words  ({word_q[2], word_q[1], word_q[0]}),
        .err    (err_q),
        .offset (off_q),
        .window (window)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            // An outstanding read must still be absorbed. If its response
            // lands in the flush cycle it is already consumed, so go idle.
            if ((state_q == WAIT || state_q == DRAIN) && !mem_valid_i) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE:    if (pc_valid_i)    state_d = FILL;
                FILL:    state_d = all_hit ? OUT : WAIT;
                WAIT:    if (mem_valid_i)   state_d = FILL;
                DRAIN:   if (mem_valid_i)   state_d = IDLE;
                OUT:     if (instr_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- Buffer and memory request datapath ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            base_q  <= '0;
            off_q   <= 3'd0;
            need3_q <= 1'b0;
            vld_q   <= 3'b000;
            err_q   <= 3'b000;
            idx_q   <= 2'd0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                word_q[i] <= 64'd0;
            end
        end else begin
            req_q <= 1'b0;
            if (flush_i) begin
                vld_q <= 3'b000;
                err_q <= 3'b000;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (pc_valid_i) begin
                            off_q   <= pc_i[2:0];
                            need3_q <= &pc_i[2:0];
                            base_q  <= new_base;
                            if (!REUSE_EN) begin
                                vld_q <= 3'b000;
                                err_q <= 3'b000;
                            end else if (delta == '0) begin
                                vld_q <= vld_q;
                            end else if (delta == ADDR_W'(8)) begin
                                word_q[0] <= word_q[1];
                                word_q[1] <= word_q[2];
                                vld_q     <= {1'b0, vld_q[2:1]};
                                err_q     <= {1'b0, err_q[2:1]};
                            end else if (delta == ADDR_W'(16)) begin
                                word_q[0] <= word_q[2];
                                vld_q     <= {2'b00, vld_q[2]};
                                err_q     <= {2'b00, err_q[2]};
                            end else begin
                                vld_q <= 3'b000;
                                err_q <= 3'b000;
                            end
                        end
                    end
                    FILL: begin
                        if (!all_hit) begin
                            req_q  <= 1'b1;
                            idx_q  <= miss_idx;
                            addr_q <= base_q + {{(ADDR_W-5){1'b0}}, miss_idx, 3'b000};
                        end
                    end
                    WAIT: begin
                        if (mem_valid_i) begin
                            word_q[idx_q] <= mem_rdata_i;
                            vld_q[idx_q]  <= 1'b1;
                            err_q[idx_q]  <= mem_error_i;
                        end
                    end
                    OUT: begin
                        // Errored data must never be served again.
                        if (instr_ready_i && win_err) begin
                            vld_q <= 3'b000;
                            err_q <= 3'b000;
                        end
                    end
                    default: begin
                        vld_q <= vld_q;
                    end
                endcase
            end
        end
    end

    // ---------------- Outputs ----------------
    assign pc_ready_o    = (state_q == IDLE);
    assign mem_req_o     = req_q;
    assign mem_addr_o    = addr_q;
    assign instr_valid_o = (state_q == OUT);
    assign instr_o       = (state_q == OUT) ? window : 80'd0;
    assign imem_error_o  = (state_q == OUT) && win_err;

endmodule
